uart_tx_sched: RTL and testbench

Transmit-side scheduler for the UART link. It shares the single UART transmitter between two requesters and paces bytes so none are dropped while the transmitter is busy:
- the Sobel edge-result FIFO (stream, byte granularity);
- the command-response generator (multi-byte packets).

It drives the one-cycle tx_flag pulse and the tx_data byte into uart_ctrl. The transmitter gives no done/busy feedback, so byte completion is timed by an internal counter.

---
 rtl/uart_tx_sched_if.sv | 43 ++++
 rtl/uart_tx_sched.sv | 120 ++++++++++++
 tb/tb_uart_tx_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: bundles the two requester channels and the transmitter
// launch port of the UART transmit scheduler.
//
// Signals:
//   res_empty  edge-result FIFO empty
//   res_rd_en  FIFO read strobe, one-cycle pulse; res_data is valid next cycle
//   res_data   FIFO read data
//   rsp_valid  response byte available
//   rsp_data   response byte
//   rsp_last   marks rsp_data as the final byte of a packet
//   rsp_ready  response acceptance
//   tx_flag    one-cycle transmit start pulse to uart_ctrl
//   tx_data    byte to transmit, held until the next launch
//
// Handshake rules: a response byte moves on the rising clock edge where
// rsp_valid && rsp_ready are both high; the source holds rsp_valid, rsp_data
// and rsp_last stable until that edge, and rsp_ready may depend
// combinationally on rsp_valid. The result FIFO is a read-strobe port: a
// res_rd_en pulse pops one byte, which is presented on res_data during the
// following cycle. tx_flag is a bare pulse with no back-pressure.
//
// Modports: master = scheduler side, slave = requesters + transmitter side.
interface uart_tx_sched_if;
  logic       res_empty;
  logic       res_rd_en;
  logic [7:0] res_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_ready;
  logic       tx_flag;
  logic [7:0] tx_data;

  modport master (
    input  res_empty, res_data, rsp_valid, rsp_data, rsp_last,
    output res_rd_en, rsp_ready, tx_flag, tx_data
  );

  modport slave (
    output res_empty, res_data, rsp_valid, rsp_data, rsp_last,
    input  res_rd_en, rsp_ready, tx_flag, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between the edge-result FIFO
// and the command-response generator, pacing bytes with an internal byte
// timer because the transmitter reports no busy/done status.
//
// Parameters:
//   CLK_DIV  sclk cycles per UART bit (matches the divider in uart_ctrl)
//   GAP_CYC  idle sclk cycles appended after each stop bit
//   CNT_W    byte-timer width, must hold 10*CLK_DIV+GAP_CYC
//
// Ports:
//   sclk       system clock
//   rst_n      asynchronous active-low reset
//   en         scheduler enable, sampled only in IDLE
//   bus        uart_tx_sched_if.master (FIFO, response and launch signals)
//   busy       high in every state except IDLE
//   grant      owner of the current/last byte: 0 = results, 1 = response
//   state_dbg  current FSM state (IDLE=0, FETCH=1, LAUNCH=2, WAIT=3)
module uart_tx_sched #(
  parameter int CLK_DIV = 5208,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic            sclk,
  input  logic            rst_n,
  input  logic            en,
  uart_tx_sched_if.master bus,
  output logic            busy,
  output logic            grant,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LAUNCH = 2'd2, WAIT = 2'd3} state_t;

  localparam int               BYTE_CYC = 10 * CLK_DIV + GAP_CYC;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       tx_data_q;
  logic             grant_q;
  logic             lock_q;
  logic             serve_res, serve_rsp;

  // Arbitration, evaluated only in IDLE with en high. A locked packet
  // excludes the FIFO entirely; otherwise a tie goes opposite to the last
  // grant. rst_n gates the strobes so they read 0 while reset is held.
  always_comb begin
    serve_res = 1'b0;
    serve_rsp = 1'b0;
    if (rst_n && state_q == IDLE && en) begin
      if (lock_q) begin
        serve_rsp = bus.rsp_valid;
      end else if (!bus.res_empty && bus.rsp_valid) begin
        serve_res = grant_q;
        serve_rsp = !grant_q;
      end else if (!bus.res_empty) begin
        serve_res = 1'b1;
      end else begin
        serve_rsp = bus.rsp_valid;
      end
    end
  end

  // State register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (serve_res)      state_d = FETCH;
        else if (serve_rsp) state_d = LAUNCH;
      end
      FETCH:  state_d = LAUNCH;
      LAUNCH: state_d = WAIT;
      WAIT:   if (cnt_q == LAST_CNT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.res_rd_en = serve_res;
    bus.rsp_ready = serve_rsp;
    bus.tx_flag   = (state_q == LAUNCH);
    bus.tx_data   = tx_data_q;
    busy          = (state_q != IDLE);
    grant         = grant_q;
    state_dbg     = state_q;
  end

  // Datapath: byte register, owner, packet lock and byte timer.
  // The timer starts at 1 in LAUNCH so that leaving WAIT at BYTE_CYC-1
  // puts the first IDLE cycle exactly BYTE_CYC cycles after tx_flag.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= 8'h00;
      grant_q   <= 1'b1;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (state_q == FETCH)  tx_data_q <= bus.res_data;
      else if (serve_rsp)    tx_data_q <= bus.rsp_data;

      if (serve_res) grant_q <= 1'b0;
      if (serve_rsp) begin
        grant_q <= 1'b1;
        lock_q  <= !bus.rsp_last;
      end

      if (state_q == LAUNCH)    cnt_q <= CNT_W'(1);
      else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched with CLK_DIV=4,
// GAP_CYC=2 (BYTE_CYC=42). A behavioural FIFO and response source feed the
// scheduler from queues; every expected launched byte {grant,data} is queued
// when stimulus is driven and compared when tx_flag fires.
module tb_uart_tx_sched;

  logic       sclk = 1'b0;
  logic       rst_n, en;
  logic       res_empty, rsp_valid, rsp_last;
  logic [7:0] res_data, rsp_data;
  logic       res_rd_en, rsp_ready, tx_flag;
  logic [7:0] tx_data;
  logic       busy, grant;
  logic [1:0] state_dbg;

  uart_tx_sched_if bus_if ();

  assign bus_if.res_empty = res_empty;
  assign bus_if.res_data  = res_data;
  assign bus_if.rsp_valid = rsp_valid;
  assign bus_if.rsp_data  = rsp_data;
  assign bus_if.rsp_last  = rsp_last;
  assign res_rd_en        = bus_if.res_rd_en;
  assign rsp_ready        = bus_if.rsp_ready;
  assign tx_flag          = bus_if.tx_flag;
  assign tx_data          = bus_if.tx_data;

  uart_tx_sched #(.CLK_DIV(4), .GAP_CYC(2), .CNT_W(16)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus_if.master),
    .busy      (busy),
    .grant     (grant),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] fifo_q[$];
  logic [8:0] rsp_q[$];
  logic [8:0] exp_q[$];
  int         flag_t[$];
  int         rd_t[$];
  logic       g_q[$];
  int         checks = 0;
  int         failures = 0;
  int         rd_count = 0;
  int         rdy_count = 0;
  logic       rd_pend, hs_pend, prev_flag, prev_ok;
  logic [7:0] prev_data;

  // Source models + output monitor. Sources change at the falling edge;
  // DUT outputs are sampled 2 time units later.
  initial begin
    logic [8:0] e;
    res_empty = 1'b1; res_data = 8'h00; rsp_valid = 1'b0; rsp_data = 8'h00; rsp_last = 1'b0;
    rd_pend = 1'b0; hs_pend = 1'b0; prev_flag = 1'b0; prev_ok = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge sclk);
      if (rd_pend && fifo_q.size() > 0) res_data = fifo_q.pop_front();
      if (hs_pend && rsp_q.size() > 0) void'(rsp_q.pop_front());
      res_empty = (fifo_q.size() == 0);
      rsp_valid = (rsp_q.size() > 0);
      if (rsp_q.size() > 0) {rsp_last, rsp_data} = rsp_q[0];
      #2;
      if (!rst_n) begin
        rd_pend = 1'b0; hs_pend = 1'b0; prev_flag = 1'b0; prev_ok = 1'b0;
      end else begin
        rd_pend = res_rd_en;
        hs_pend = rsp_valid && rsp_ready;
        if (res_rd_en) begin rd_count++; rd_t.push_back(cyc); end
        if (rsp_ready) rdy_count++;
        if (tx_flag) begin
          checks++;
          if (prev_flag) begin
            failures++;
            $display("FAIL tx_flag_double cycle=%0d got two consecutive high cycles, exp single pulse", cyc);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tx_unexpected cycle=%0d got grant=%0b data=%h exp no launch", cyc, grant, tx_data);
          end else begin
            e = exp_q.pop_front();
            if ({grant, tx_data} !== e) begin
              failures++;
              $display("FAIL tx_byte cycle=%0d got grant=%0b data=%h exp grant=%0b data=%h",
                       cyc, grant, tx_data, e[8], e[7:0]);
            end
          end
          flag_t.push_back(cyc);
          g_q.push_back(grant);
        end
        if (prev_ok && !tx_flag) begin
          checks++;
          if (tx_data !== prev_data) begin
            failures++;
            $display("FAIL tx_data_stable cycle=%0d got %h exp %h", cyc, tx_data, prev_data);
          end
        end
        prev_flag = tx_flag;
        prev_data = tx_data;
        prev_ok   = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_res(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic push_rsp(input logic last, input logic [7:0] d);
    rsp_q.push_back({last, d});
  endtask

  task automatic do_reset();
    @(posedge sclk); #1 rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge sclk); #3;
      if (fifo_q.size() == 0 && rsp_q.size() == 0 && exp_q.size() == 0 &&
          busy === 1'b0 && !rd_pend && !hs_pend) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout got %0d bytes still expected, exp 0 within %0d cycles", tag, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_flags(input int target, input int budget, input string tag);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge sclk); #3;
      if (flag_t.size() >= target) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_flag_timeout got %0d flags exp %0d", tag, flag_t.size(), target);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge sclk); #3;
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_idle_timeout got busy=%0b exp 0", tag, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    checks++;
    if ({tx_flag, res_rd_en, rsp_ready, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got flag/rd/ready/busy=%b exp 0000", {tx_flag, res_rd_en, rsp_ready, busy});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx_data got %h exp 00", tx_data);
    end
    checks++;
    if (grant !== 1'b1) begin
      failures++;
      $display("FAIL reset_grant got %0b exp 1", grant);
    end
    @(posedge sclk); #1 rst_n = 1'b1;
  endtask

  task automatic test_results();
    int fb = flag_t.size();
    int rb = rd_count;
    @(posedge sclk); #1;
    push_res(8'hA5);
    push_res(8'h3C);
    wait_quiet(400, "results");
    checks++;
    if (flag_t.size() - fb !== 2) begin
      failures++;
      $display("FAIL results_count got %0d exp 2", flag_t.size() - fb);
    end else begin
      checks++;
      if (flag_t[fb+1] - flag_t[fb] !== 44) begin
        failures++;
        $display("FAIL results_spacing got %0d exp 44", flag_t[fb+1] - flag_t[fb]);
      end
    end
    checks++;
    if (rd_count - rb !== 2) begin
      failures++;
      $display("FAIL results_rd_pulses got %0d exp 2", rd_count - rb);
    end
    checks++;
    if (grant !== 1'b0) begin
      failures++;
      $display("FAIL results_grant got %0b exp 0", grant);
    end
  endtask

  task automatic test_packet();
    int fb = flag_t.size();
    int rb = rd_t.size();
    @(posedge sclk); #1;
    // grant is 0, so the tie goes to the response packet
    push_rsp(1'b0, 8'h11); exp_q.push_back({1'b1, 8'h11});
    push_rsp(1'b0, 8'h22); exp_q.push_back({1'b1, 8'h22});
    push_rsp(1'b1, 8'h33); exp_q.push_back({1'b1, 8'h33});
    push_res(8'h77);
    wait_quiet(600, "packet");
    checks++;
    if (flag_t.size() - fb !== 4) begin
      failures++;
      $display("FAIL packet_count got %0d exp 4", flag_t.size() - fb);
    end else begin
      checks++;
      if (flag_t[fb+1] - flag_t[fb] !== 43 || flag_t[fb+2] - flag_t[fb+1] !== 43) begin
        failures++;
        $display("FAIL packet_spacing got %0d,%0d exp 43,43",
                 flag_t[fb+1] - flag_t[fb], flag_t[fb+2] - flag_t[fb+1]);
      end
      checks++;
      if (rd_t.size() - rb !== 1) begin
        failures++;
        $display("FAIL packet_rd_pulses got %0d exp 1", rd_t.size() - rb);
      end else begin
        checks++;
        if (rd_t[rb] - flag_t[fb+2] !== 42) begin
          failures++;
          $display("FAIL packet_rd_after_last got %0d cycles after last byte exp 42", rd_t[rb] - flag_t[fb+2]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int fb;
    logic [3:0] pat = 4'b1010;
    int gaps[3] = '{43, 44, 43};
    do_reset();
    fb = flag_t.size();
    @(posedge sclk); #1;
    push_res(8'hC1);
    push_res(8'hC2);
    push_rsp(1'b1, 8'hD1);
    push_rsp(1'b1, 8'hD2);
    // grant resets to 1, so results win the first tie
    exp_q.delete();
    exp_q.push_back({1'b0, 8'hC1});
    exp_q.push_back({1'b1, 8'hD1});
    exp_q.push_back({1'b0, 8'hC2});
    exp_q.push_back({1'b1, 8'hD2});
    wait_quiet(600, "rr");
    checks++;
    if (flag_t.size() - fb !== 4) begin
      failures++;
      $display("FAIL rr_count got %0d exp 4", flag_t.size() - fb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g_q[fb+i] !== pat[i]) begin
          failures++;
          $display("FAIL rr_grant_%0d got %0b exp %0b", i, g_q[fb+i], pat[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (flag_t[fb+i+1] - flag_t[fb+i] !== gaps[i]) begin
          failures++;
          $display("FAIL rr_spacing_%0d got %0d exp %0d", i, flag_t[fb+i+1] - flag_t[fb+i], gaps[i]);
        end
      end
    end
  endtask

  task automatic test_enable();
    int fb = flag_t.size();
    int fc, rc, yc;
    @(posedge sclk); #1;
    push_res(8'h5A);
    wait_flags(fb + 1, 100, "en");
    @(posedge sclk); #1 en = 1'b0;
    push_rsp(1'b1, 8'h44);
    fifo_q.push_back(8'h66);
    exp_q.push_back({1'b1, 8'h44});
    exp_q.push_back({1'b0, 8'h66});
    wait_idle(100, "en");
    checks++;
    if (flag_t.size() > fb && cyc - flag_t[fb] !== 42) begin
      failures++;
      $display("FAIL en_byte_time got %0d exp 42", cyc - flag_t[fb]);
    end
    fc = flag_t.size(); rc = rd_count; yc = rdy_count;
    repeat (20) @(negedge sclk);
    #3;
    checks++;
    if (flag_t.size() !== fc || rd_count !== rc || rdy_count !== yc) begin
      failures++;
      $display("FAIL en_low_quiet got flags=%0d rd=%0d ready=%0d exp 0 0 0",
               flag_t.size() - fc, rd_count - rc, rdy_count - yc);
    end
    @(posedge sclk); #1 en = 1'b1;
    #1;
    checks++;
    if ({rsp_ready, res_rd_en} !== 2'b10) begin
      failures++;
      $display("FAIL en_resume got ready/rd=%b exp 10", {rsp_ready, res_rd_en});
    end
    wait_quiet(400, "en");
  endtask

  task automatic test_reset_mid_wait();
    int fb = flag_t.size();
    int rb;
    @(posedge sclk); #1;
    // grant is 0 after 0x66: the response wins and opens a packet
    push_rsp(1'b0, 8'h81);
    exp_q.push_back({1'b1, 8'h81});
    fifo_q.push_back(8'h99);
    wait_flags(fb + 1, 100, "lock");
    rb = rd_count;
    wait_idle(100, "lock");
    repeat (10) @(negedge sclk);
    #3;
    checks++;
    if (rd_count !== rb || busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_hold got rd=%0d busy=%0b exp rd=0 busy=0", rd_count - rb, busy);
    end
    @(posedge sclk); #1;
    push_rsp(1'b0, 8'h82);
    exp_q.push_back({1'b1, 8'h82});
    wait_flags(fb + 2, 100, "lock2");
    repeat (10) @(posedge sclk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_flag, busy, res_rd_en, rsp_ready, grant} !== 5'b00001) begin
      failures++;
      $display("FAIL rst_mid_ctrl got flag/busy/rd/ready/grant=%b exp 00001",
               {tx_flag, busy, res_rd_en, rsp_ready, grant});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_tx_data got %h exp 00", tx_data);
    end
    push_rsp(1'b1, 8'h55);
    exp_q.push_back({1'b0, 8'h99});
    exp_q.push_back({1'b1, 8'h55});
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
    wait_quiet(400, "rst_mid");
    checks++;
    if (flag_t.size() - fb !== 4) begin
      failures++;
      $display("FAIL rst_mid_count got %0d exp 4", flag_t.size() - fb);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_results();
    test_packet();
    test_round_robin();
    test_enable();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
